exe_csr_pipe: RTL and testbench
===============================

# exe_csr_pipe

Two-stage, parametrised CSR execute unit with valid/ready handshakes on both sides. It issues the CSR read, computes the read-modify-write result, and returns the old CSR value to writeback. It commits the CSR write only at retirement. Sits between decode/issue and writeback, and owns the read and write ports of the CSR register file.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `IMM_LEN`, 5, zimm width, zero-extended to XLEN
- `CSR_AW`, 12, CSR address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `flush`  in  1  synchronous kill of both stages
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid & in_ready`
- `in_op`  in  `CSROP_LEN`  `CSROP_NONE/READ/WRITE/SET/CLEAR`
- `in_addr`  in  CSR_AW  CSR address
- `in_rs1_data`  in  XLEN  register operand
- `in_zimm`  in  IMM_LEN  immediate operand
- `in_use_imm`  in  1  1: operand = zext(in_zimm), else in_rs1_data
- `csr_raddr`  out  CSR_AW  CSR file read address
- `csr_rdata`  in  XLEN  combinational read data for `csr_raddr`
- `csr_wen`  out  1  CSR file write strobe
- `csr_waddr`  out  CSR_AW  write address
- `csr_wdata`  out  XLEN  write data
- `out_valid`  out  1  result valid
- `out_ready`  in  1  writeback accepts
- `out_rd_data`  out  XLEN  old CSR value; 0 for NONE
- `out_illegal`  out  1  illegal-access flag, qualified by `out_valid`

## Operation
- S1 register: captures op, addr, and the resolved operand on input handshake. `csr_raddr = s1_addr`.
- S1 computes `old = csr_rdata` (or the forwarded value, see Configuration).
- S1 computes `new` by op:
  - WRITE: `new = opnd`
  - SET: `new = old | opnd`
  - CLEAR: `new = old & ~opnd`
  - READ/NONE: no write
- Illegal is computed in S1: `addr[CSR_AW-1:CSR_AW-2]==2'b11` (read-only) and op ∈ {WRITE, SET, CLEAR}. An illegal op writes nothing; `out_rd_data` still returns `old`.
- Unknown op encodings behave as NONE.
- S2 register holds `rd_data`, `wen`, `waddr`, `wdata`, and `illegal`.
- On `out_valid & out_ready & ~flush`: `csr_wen = s2_wen`, and the write takes effect at that clock edge. `csr_wen` is 0 in every other cycle.
- Hazard: S1 valid, S2 valid with `s2_wen`, and `s1_addr == s2_waddr`.
- Flow control:
  - `s1_adv = s1_valid & ~stall & (~s2_valid | out_ready)`
  - `in_ready = ~s1_valid | s1_adv`
  - `out_valid = s2_valid`
- `flush`: S1 and S2 become invalid at the next edge. In the flush cycle, `csr_wen` is forced to 0 even if S2 handshakes, and no input is accepted (`in_ready` is don't-care while `flush` = 1).
- `rst`: same effect as flush.

## Timing
- Reset values:
  - `s1_valid = s2_valid = 0`
  - `out_valid = 0`, `csr_wen = 0`, `in_ready = 1`
  - `out_rd_data = 0`, `out_illegal = 0`, `csr_waddr = 0`, `csr_wdata = 0`
- Latency: accept at edge N makes `out_valid = 1` after edge N+1 (2 cycles), provided there is no stall.
- Throughput: 1 op/cycle when there is no hazard and `out_ready` is held high.
- The CSR write is visible in the file after the retirement edge.
- Backpressure: S2 holds all outputs stable while `out_valid & ~out_ready`. S1 holds when S2 is blocked.
- Simultaneous S2 retire and S1 hazard:
  - Without forwarding, S1 stalls that cycle and advances the next, reading the committed value.
  - With forwarding, S1 takes `s2_wdata` and advances in the same cycle.

## Configuration
- `CSR_FWD_EN` defined:
  - On hazard, S1 uses `s2_wdata` as `old`.
  - `stall = 0`.
- Undefined:
  - `stall = hazard`.
  - S1 waits until S2 has retired, then reads `csr_rdata`.
  - Back-to-back dependent ops cost 1 extra cycle.
- Results are identical in both builds; only cycle counts differ.

## Test plan
- Reset, then a CSR file model with `0x300 = 0x8`. READ 0x300 → `out_valid` at cycle 2, `out_rd_data = 0x8`, `csr_wen` never asserted.
- SET 0x300 with rs1 = 0x80, then back-to-back CLEAR 0x300 with zimm = 0x8:
  - First op returns 0x8; second returns 0x88.
  - Final 0x300 = 0x80.
  - Without `CSR_FWD_EN`, the second result arrives 1 cycle later.
- WRITE 0xC00 (read-only) with 0x5 → `out_illegal = 1`, `out_rd_data` = old value, no `csr_wen`. READ 0xC00 → `out_illegal = 0`.
- Hold `out_ready = 0` for 3 cycles with two ops issued:
  - `in_ready` drops after S1 fills.
  - `out_rd_data` stays stable.
  - Both ops complete in order once `out_ready = 1`, with exactly one `csr_wen` per writing op.
- Assert `flush` in the same cycle as S2 WRITE 0x305 = 0x1000 handshakes → no `csr_wen`, 0x305 unchanged, both stages empty next cycle.
- Assert `rst` mid-stream with S1 and S2 full → next cycle `out_valid = 0`, `in_ready = 1`, no CSR write.

Source files
------------

// File: rtl/exe_csr_pipe_if.sv
// exe_csr_pipe_if
//   Bundles the request, CSR-file and result signals of exe_csr_pipe.
//   slave  : the execute unit itself
//   master : the surrounding pipeline / CSR file (drives requests, read data,
//            writeback ready and flush)
//   Op encoding on in_op (CSROP_LEN bits): 0 NONE, 1 READ, 2 WRITE, 3 SET,
//   4 CLEAR; any other code is treated as NONE.
interface exe_csr_pipe_if #(
  parameter int XLEN    = 64,
  parameter int IMM_LEN = 5,
  parameter int CSR_AW  = 12
);
  localparam int CSROP_LEN = 3;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [CSROP_LEN-1:0] in_op;
  logic [CSR_AW-1:0]    in_addr;
  logic [XLEN-1:0]      in_rs1_data;
  logic [IMM_LEN-1:0]   in_zimm;
  logic                 in_use_imm;
  logic [CSR_AW-1:0]    csr_raddr;
  logic [XLEN-1:0]      csr_rdata;
  logic                 csr_wen;
  logic [CSR_AW-1:0]    csr_waddr;
  logic [XLEN-1:0]      csr_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_rd_data;
  logic                 out_illegal;

  modport slave (
    input  flush, in_valid, in_op, in_addr, in_rs1_data, in_zimm, in_use_imm,
           csr_rdata, out_ready,
    output in_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata,
           out_valid, out_rd_data, out_illegal
  );

  modport master (
    output flush, in_valid, in_op, in_addr, in_rs1_data, in_zimm, in_use_imm,
           csr_rdata, out_ready,
    input  in_ready, csr_raddr, csr_wen, csr_waddr, csr_wdata,
           out_valid, out_rd_data, out_illegal
  );
endinterface

// File: rtl/exe_csr_pipe.sv
// exe_csr_pipe
//   Two-stage CSR execute unit. S1 holds the accepted request, reads the CSR
//   file combinationally and computes the read-modify-write value and the
//   illegal flag. S2 holds the result and commits the CSR write only when the
//   result retires (out_valid & out_ready, no flush).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (same effect as flush)
//   bus  : exe_csr_pipe_if.slave - request handshake, CSR read/write ports,
//          result handshake, flush
// Build option:
//   CSR_FWD_EN - when defined, an S1 op that depends on the pending S2 write
//   takes s2_wdata as the old value and never stalls; otherwise S1 waits for
//   S2 to retire and re-reads the committed value.
module exe_csr_pipe #(
  parameter int XLEN    = 64,
  parameter int IMM_LEN = 5,
  parameter int CSR_AW  = 12
) (
  input logic           clk,
  input logic           rst,
  exe_csr_pipe_if.slave bus
);
  localparam logic [2:0] CSROP_NONE  = 3'd0;
  localparam logic [2:0] CSROP_READ  = 3'd1;
  localparam logic [2:0] CSROP_WRITE = 3'd2;
  localparam logic [2:0] CSROP_SET   = 3'd3;
  localparam logic [2:0] CSROP_CLEAR = 3'd4;

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic [CSR_AW-1:0] s1_addr;
  logic [XLEN-1:0]   s1_opnd;

  logic              s2_valid;
  logic              s2_wen;
  logic              s2_illegal;
  logic [XLEN-1:0]   s2_rd_data;
  logic [XLEN-1:0]   s2_wdata;
  logic [CSR_AW-1:0] s2_waddr;

  logic              kill;
  logic              hazard;
  logic              stall;
  logic              s1_adv;
  logic              accept;
  logic              retire;
  logic [XLEN-1:0]   in_opnd;
  logic [XLEN-1:0]   old_val;
  logic [XLEN-1:0]   new_val;
  logic [XLEN-1:0]   rd_val;
  logic              is_read;
  logic              is_wr;
  logic              read_only;
  logic              illegal;
  logic              wen;

  assign kill   = rst | bus.flush;
  assign hazard = s1_valid & s2_valid & s2_wen & (s1_addr == s2_waddr);

`ifdef CSR_FWD_EN
  assign stall   = 1'b0;
  assign old_val = hazard ? s2_wdata : bus.csr_rdata;
`else
  // The file still holds the pre-write value until S2 retires, so S1 waits.
  assign stall   = hazard;
  assign old_val = bus.csr_rdata;
`endif

  assign s1_adv       = s1_valid & ~stall & (~s2_valid | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s1_adv;
  assign accept       = bus.in_valid & bus.in_ready & ~kill;
  assign retire       = s2_valid & bus.out_ready;

  assign in_opnd = bus.in_use_imm ? {{(XLEN-IMM_LEN){1'b0}}, bus.in_zimm}
                                  : bus.in_rs1_data;

  always_comb begin
    is_read = 1'b0;
    is_wr   = 1'b0;
    new_val = old_val;
    case (s1_op)
      CSROP_READ:  is_read = 1'b1;
      CSROP_WRITE: begin is_wr = 1'b1; new_val = s1_opnd;            end
      CSROP_SET:   begin is_wr = 1'b1; new_val = old_val | s1_opnd;  end
      CSROP_CLEAR: begin is_wr = 1'b1; new_val = old_val & ~s1_opnd; end
      default:     ;
    endcase
  end

  // Top two address bits 2'b11 mark the read-only CSR space.
  assign read_only = (s1_addr[CSR_AW-1 -: 2] == 2'b11);
  assign illegal   = is_wr & read_only;
  assign wen       = is_wr & ~read_only;
  assign rd_val    = (is_read | is_wr) ? old_val : '0;

  always_ff @(posedge clk) begin
    if (kill) begin
      s1_valid <= 1'b0;
      if (rst) begin
        s1_op   <= CSROP_NONE;
        s1_addr <= '0;
        s1_opnd <= '0;
      end
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.in_op;
      s1_addr  <= bus.in_addr;
      s1_opnd  <= in_opnd;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      s2_valid <= 1'b0;
      if (rst) begin
        s2_wen     <= 1'b0;
        s2_illegal <= 1'b0;
        s2_rd_data <= '0;
        s2_wdata   <= '0;
        s2_waddr   <= '0;
      end
    end else if (s1_adv) begin
      s2_valid   <= 1'b1;
      s2_wen     <= wen;
      s2_illegal <= illegal;
      s2_rd_data <= rd_val;
      s2_wdata   <= new_val;
      s2_waddr   <= s1_addr;
    end else if (retire) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.csr_raddr   = s1_addr;
  assign bus.csr_wen     = retire & s2_wen & ~kill;
  assign bus.csr_waddr   = s2_waddr;
  assign bus.csr_wdata   = s2_wdata;
  assign bus.out_valid   = s2_valid;
  assign bus.out_rd_data = s2_rd_data;
  assign bus.out_illegal = s2_illegal;
endmodule

// File: tb/tb_exe_csr_pipe.sv
module tb_exe_csr_pipe;
  localparam int XLEN    = 64;
  localparam int IMM_LEN = 5;
  localparam int CSR_AW  = 12;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_SET   = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  logic clk = 1'b0;
  logic rst;

  exe_csr_pipe_if #(.XLEN(XLEN), .IMM_LEN(IMM_LEN), .CSR_AW(CSR_AW)) bus ();

  exe_csr_pipe #(.XLEN(XLEN), .IMM_LEN(IMM_LEN), .CSR_AW(CSR_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic        ill;
    logic        wen;
    logic [11:0] waddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t        expq[$];
  int          ret_cyc[$];
  logic [63:0] csr_file    [4096];
  logic [63:0] spec_file   [4096];
  logic [63:0] commit_file [4096];

  assign bus.csr_rdata = csr_file[bus.csr_raddr];

  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          wen_count = 0;
  logic        last_ihs  = 1'b0;
  logic [63:0] last_rd   = '0;
  logic        last_ill  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Program-order model: each accepted op sees every earlier surviving op.
  function automatic void model_accept(input logic [2:0] op, input logic [11:0] addr,
                                       input logic [63:0] opnd);
    exp_t        e;
    logic [63:0] old;
    logic        writes;
    logic        ro;
    old    = spec_file[addr];
    writes = (op == OP_WRITE) || (op == OP_SET) || (op == OP_CLEAR);
    ro     = (addr[11:10] == 2'b11);
    e.rd    = (op == OP_READ || writes) ? old : 64'h0;
    e.ill   = writes && ro;
    e.wen   = writes && !ro;
    e.waddr = addr;
    case (op)
      OP_WRITE: e.wdata = opnd;
      OP_SET:   e.wdata = old | opnd;
      OP_CLEAR: e.wdata = old & ~opnd;
      default:  e.wdata = old;
    endcase
    if (e.wen) spec_file[addr] = e.wdata;
    expq.push_back(e);
  endfunction

  task automatic step();
    exp_t        e;
    logic        ihs;
    logic        ohs;
    logic        wen_s;
    logic [11:0] wa;
    logic [63:0] wd;
    @(negedge clk);
    ihs   = bus.in_valid && bus.in_ready && !bus.flush && !rst;
    ohs   = bus.out_valid && bus.out_ready && !bus.flush && !rst;
    wen_s = bus.csr_wen;
    wa    = bus.csr_waddr;
    wd    = bus.csr_wdata;
    if (wen_s) wen_count++;
    if (ohs) begin
      ret_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 64'(bus.out_valid), 64'h0);
      end else begin
        e = expq.pop_front();
        chk("rd_data", bus.out_rd_data, e.rd);
        chk("illegal", 64'(bus.out_illegal), 64'(e.ill));
        chk("csr_wen", 64'(wen_s), 64'(e.wen));
        if (e.wen) begin
          chk("csr_waddr", 64'(wa), 64'(e.waddr));
          chk("csr_wdata", wd, e.wdata);
          commit_file[e.waddr] = e.wdata;
        end
        last_rd  = bus.out_rd_data;
        last_ill = bus.out_illegal;
      end
    end else begin
      chk("csr_wen_idle", 64'(wen_s), 64'h0);
    end
    if (ihs)
      model_accept(bus.in_op, bus.in_addr,
                   bus.in_use_imm ? {59'b0, bus.in_zimm} : bus.in_rs1_data);
    if (rst || bus.flush) begin
      expq.delete();
      spec_file = commit_file;
    end
    last_ihs = ihs;
    @(posedge clk);
    #1;
    cyc++;
    if (wen_s) csr_file[wa] = wd;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [63:0] rs1,
                       input logic [4:0] zimm, input logic use_imm);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_addr     = addr;
    bus.in_rs1_data = rs1;
    bus.in_zimm     = zimm;
    bus.in_use_imm  = use_imm;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_ihs) break;
    end
    chk("issue_accepted", 64'(last_ihs), 64'h1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || bus.out_valid) && n < 50) begin
      step();
      n++;
    end
    chk("drain_done", 64'(expq.size()), 64'h0);
  endtask

  task automatic preset(input logic [11:0] a, input logic [63:0] v);
    csr_file[a]    = v;
    spec_file[a]   = v;
    commit_file[a] = v;
  endtask

  initial begin
    int          wc0;
    logic [11:0] addrs [5];
    addrs = '{12'h300, 12'h301, 12'h305, 12'hC00, 12'hC01};
    for (int i = 0; i < 4096; i++) preset(12'(i), 64'h0);
    preset(12'h300, 64'h8);
    preset(12'h301, 64'h11);
    preset(12'h305, 64'h77);
    preset(12'hC00, 64'h1234);

    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = OP_NONE;
    bus.in_addr     = '0;
    bus.in_rs1_data = '0;
    bus.in_zimm     = '0;
    bus.in_use_imm  = 1'b0;
    bus.out_ready   = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_csr_wen", 64'(bus.csr_wen), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_rd_data", bus.out_rd_data, 64'h0);
    chk("rst_illegal", 64'(bus.out_illegal), 64'h0);
    chk("rst_waddr", 64'(bus.csr_waddr), 64'h0);
    chk("rst_wdata", bus.csr_wdata, 64'h0);

    // READ: two-cycle latency, no write
    wc0 = wen_count;
    issue(OP_READ, 12'h300, 64'h0, 5'h0, 1'b0);
    chk("lat_after_accept", 64'(bus.out_valid), 64'h0);
    step();
    chk("lat_out_valid", 64'(bus.out_valid), 64'h1);
    chk("read_300", bus.out_rd_data, 64'h8);
    drain();
    chk("read_no_wen", 64'(wen_count), 64'(wc0));

    // Dependent SET then CLEAR on the same CSR
    ret_cyc.delete();
    issue(OP_SET, 12'h300, 64'h80, 5'h0, 1'b0);
    issue(OP_CLEAR, 12'h300, 64'h0, 5'h8, 1'b1);
    drain();
    chk("dep_results", 64'(ret_cyc.size()), 64'h2);
    if (ret_cyc.size() == 2) begin
`ifdef CSR_FWD_EN
      chk("dep_gap", 64'(ret_cyc[1] - ret_cyc[0]), 64'h1);
`else
      chk("dep_gap", 64'(ret_cyc[1] - ret_cyc[0]), 64'h2);
`endif
    end
    chk("clear_rd", last_rd, 64'h88);
    chk("final_300", csr_file[12'h300], 64'h80);

    // Read-only CSR
    issue(OP_WRITE, 12'hC00, 64'h5, 5'h0, 1'b0);
    drain();
    chk("ro_illegal", 64'(last_ill), 64'h1);
    chk("ro_old", last_rd, 64'h1234);
    chk("ro_unchanged", csr_file[12'hC00], 64'h1234);
    issue(OP_READ, 12'hC00, 64'h0, 5'h0, 1'b0);
    drain();
    chk("ro_read_legal", 64'(last_ill), 64'h0);
    chk("ro_read_val", last_rd, 64'h1234);

    // Backpressure
    bus.out_ready = 1'b0;
    wc0 = wen_count;
    issue(OP_WRITE, 12'h301, 64'hAA, 5'h0, 1'b0);
    issue(OP_SET, 12'h302, 64'h3, 5'h0, 1'b0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_hold_rd", bus.out_rd_data, expq[0].rd);
      chk("bp_in_ready_hold", 64'(bus.in_ready), 64'h0);
    end
    chk("bp_no_wen", 64'(wen_count), 64'(wc0));
    bus.out_ready = 1'b1;
    drain();
    chk("bp_wen_count", 64'(wen_count), 64'(wc0 + 2));
    chk("bp_301", csr_file[12'h301], 64'hAA);
    chk("bp_302", csr_file[12'h302], 64'h3);

    // Flush while S2 WRITE handshakes
    bus.out_ready = 1'b0;
    wc0 = wen_count;
    issue(OP_WRITE, 12'h305, 64'h1000, 5'h0, 1'b0);
    issue(OP_READ, 12'h300, 64'h0, 5'h0, 1'b0);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'h1);
    chk("flush_305", csr_file[12'h305], 64'h77);
    chk("flush_no_wen", 64'(wen_count), 64'(wc0));
    step();
    chk("flush_empty", 64'(bus.out_valid), 64'h0);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    wc0 = wen_count;
    issue(OP_WRITE, 12'h301, 64'h5555, 5'h0, 1'b0);
    issue(OP_SET, 12'h300, 64'h1, 5'h0, 1'b0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("mrst_rd_data", bus.out_rd_data, 64'h0);
    chk("mrst_no_wen", 64'(wen_count), 64'(wc0));
    chk("mrst_301", csr_file[12'h301], 64'hAA);
    step();
    chk("mrst_empty", 64'(bus.out_valid), 64'h0);

    // Random traffic against the program-order model
    for (int i = 0; i < 400; i++) begin
      bus.in_valid    = ($urandom_range(0, 99) < 70);
      bus.in_op       = 3'($urandom_range(0, 7));
      bus.in_addr     = addrs[$urandom_range(0, 4)];
      bus.in_rs1_data = {$urandom(), $urandom()};
      bus.in_zimm     = 5'($urandom());
      bus.in_use_imm  = 1'($urandom());
      bus.out_ready   = ($urandom_range(0, 99) < 70);
      bus.flush       = ($urandom_range(0, 99) < 3);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    for (int i = 0; i < 5; i++)
      chk("rand_file", csr_file[addrs[i]], commit_file[addrs[i]]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
